// File: rtl/trigger_capture.sv
// trigger_capture: armed, trigger-qualified frame capture of a signed sample
// stream. Once armed, a valid sample carrying the trigger flag starts a frame
// of N_SAMPLES forwarded samples. The frame is followed by HOLDOFF valid
// samples that are ignored before the block re-arms.
//
// Build option: define TRIG_CAPTURE_AUTO_REARM_EN to return to ARMED after
// the holdoff window, which gives continuous triggered capture. Without it,
// the block returns to IDLE, capture is one-shot, and a new arm request is
// needed for the next frame.
module trigger_capture #(
  parameter int N_SAMPLES = 1024,  // samples per frame, 1..2^16
  parameter int HOLDOFF   = 16     // valid samples skipped after a frame, 0..2^16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [31:0] data_in,
  input  logic               data_in_valid,
  input  logic               trigger,
  input  logic               arm,
  output logic signed [31:0] data_out,
  output logic               data_out_valid,
  output logic               frame_start,
  output logic               frame_end,
  output logic               armed,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_HOLDOFF
  } state_e;

  // Index of the final sample in a frame, and of the final holdoff sample.
  localparam logic [16:0] LAST_IDX  = 17'(N_SAMPLES - 1);
  localparam logic [16:0] HOLD_LAST = (HOLDOFF > 0) ? 17'(HOLDOFF - 1) : 17'd0;
  localparam bit          HOLD_ZERO = (HOLDOFF == 0);

`ifdef TRIG_CAPTURE_AUTO_REARM_EN
  localparam state_e HOLDOFF_EXIT = S_ARMED;
`else
  localparam state_e HOLDOFF_EXIT = S_IDLE;
`endif

  state_e             state_q;
  logic        [16:0] cnt_q;         // sample index in CAPTURE, skipped samples in HOLDOFF
  logic signed [31:0] data_out_q;
  logic               data_out_valid_q;
  logic               frame_start_q;
  logic               frame_end_q;
  logic        [16:0] cnt_inc;

  // Sample 0 is accepted on the ARMED->CAPTURE edge. While in CAPTURE, cnt_q
  // holds the index of the last forwarded sample, so the next index is cnt_q+1.
  assign cnt_inc = cnt_q + 17'd1;

  // Control FSM with registered output stage. Every accepted sample shows up
  // one cycle later.
  // NOTE: all state here is assigned non-blocking so every register samples
  // pre-edge values; blocking assignments would leak updates between lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_end_q      <= 1'b0;
    end else begin
      // Pulse outputs default low. data_out keeps its last value.
      data_out_valid_q <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_end_q      <= 1'b0;

      case (state_q)
        // Only arm is acted on here; a simultaneous trigger is dropped.
        S_IDLE: begin
          if (arm) begin
            state_q <= S_ARMED;
            cnt_q   <= '0;
          end
        end

        // A trigger only counts when it arrives with a valid sample.
        S_ARMED: begin
          if (data_in_valid && trigger) begin
            data_out_q       <= data_in;
            data_out_valid_q <= 1'b1;
            frame_start_q    <= 1'b1;
            cnt_q            <= '0;
            if (LAST_IDX == 17'd0) begin
              frame_end_q <= 1'b1;
              state_q     <= S_HOLDOFF;
            end else begin
              state_q <= S_CAPTURE;
            end
          end
        end

        // Forward valid samples. Gaps in data_in_valid stall the index.
        S_CAPTURE: begin
          if (data_in_valid) begin
            data_out_q       <= data_in;
            data_out_valid_q <= 1'b1;
            if (cnt_inc == LAST_IDX) begin
              frame_end_q <= 1'b1;
              state_q     <= S_HOLDOFF;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        // Skip HOLDOFF valid samples. A zero holdoff passes through in one cycle.
        S_HOLDOFF: begin
          if (HOLD_ZERO) begin
            state_q <= HOLDOFF_EXIT;
            cnt_q   <= '0;
          end else if (data_in_valid) begin
            if (cnt_q == HOLD_LAST) begin
              state_q <= HOLDOFF_EXIT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign frame_start    = frame_start_q;
  assign frame_end      = frame_end_q;
  assign armed          = (state_q == S_ARMED);
  assign busy           = (state_q == S_CAPTURE) || (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed bench for trigger_capture.
// Main DUT: N_SAMPLES=4, HOLDOFF=8, checked through a scoreboard.
// Second DUT: N_SAMPLES=1, HOLDOFF=0, the single-sample boundary case.
module tb_trigger_capture;

`ifdef TRIG_CAPTURE_AUTO_REARM_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [31:0] data_in;
  logic               data_in_valid;
  logic               trigger;
  logic               arm;

  logic signed [31:0] data_out;
  logic               data_out_valid, frame_start, frame_end, armed, busy;
  logic signed [31:0] d1_data_out;
  logic               d1_valid, d1_start, d1_end, d1_armed, d1_busy;

  typedef struct {
    logic signed [31:0] data;
    logic               fs;
    logic               fe;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_out = 0;

  always #5 clk = ~clk;

  trigger_capture #(.N_SAMPLES(4), .HOLDOFF(8)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_in_valid(data_in_valid),
    .trigger(trigger), .arm(arm), .data_out(data_out), .data_out_valid(data_out_valid),
    .frame_start(frame_start), .frame_end(frame_end), .armed(armed), .busy(busy)
  );

  trigger_capture #(.N_SAMPLES(1), .HOLDOFF(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_in_valid(data_in_valid),
    .trigger(trigger), .arm(arm), .data_out(d1_data_out), .data_out_valid(d1_valid),
    .frame_start(d1_start), .frame_end(d1_end), .armed(d1_armed), .busy(d1_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input beat at the falling edge. The DUT samples it on the next rising edge.
  task automatic drive(input logic v, input logic t, input logic a, input logic signed [31:0] d);
    @(negedge clk);
    data_in_valid = v;
    trigger       = t;
    arm           = a;
    data_in       = d;
  endtask

  task automatic push(input logic signed [31:0] d, input logic fs, input logic fe);
    beat_t b;
    b.data = d;
    b.fs   = fs;
    b.fe   = fe;
    sb_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    data_in_valid = 1'b0; trigger = 1'b0; arm = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor for the main DUT. It runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (data_out_valid) begin
        n_out++;
        n_cmp++;
        assert (sb_q.size() > 0) else begin
          n_err++;
          $error("FAIL sb_unexpected: observed data_out=%0d valid with no expected beat", data_out);
        end
        if (sb_q.size() > 0) begin
          beat_t b;
          b = sb_q.pop_front();
          check("sb_data", data_out, b.data);
          check("sb_frame_start", frame_start, b.fs);
          check("sb_frame_end", frame_end, b.fe);
        end
      end else begin
        check("idle_pulses", {30'd0, frame_start, frame_end}, 32'd0);
      end
    end
  end

  initial begin
    int outs_before;
    reset_n = 1'b1;
    data_in_valid = 1'b0; trigger = 1'b0; arm = 1'b0; data_in = '0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;

    // Arm and trigger together in IDLE: the block arms and the sample is not captured.
    drive(1, 1, 1, 777);
    drive(0, 0, 0, 0);
    check("arm_only_armed", armed, 1);
    check("arm_only_busy", busy, 0);
    check("d1_arm_only_valid", d1_valid, 0);

    // Four-sample frame starting at 4001. A repeat trigger mid-frame is ignored.
    drive(1, 1, 0, 4001); push(4001, 1, 0);
    drive(1, 0, 0, 4002); push(4002, 0, 0);
    check("cap_busy", busy, 1);
    check("cap_armed", armed, 0);
    check("d1_data", d1_data_out, 4001);
    check("d1_valid", d1_valid, 1);
    check("d1_start_end", {30'd0, d1_start, d1_end}, 32'd3);
    check("d1_busy_holdoff", d1_busy, 1);
    drive(1, 1, 0, 4003); push(4003, 0, 0);
    check("d1_busy_after_zero_holdoff", d1_busy, 0);
    check("d1_rearm_mode", d1_armed, AUTO);
    drive(1, 0, 0, 4004); push(4004, 0, 1);
    check("d1_recapture_mode", d1_valid, AUTO);

    // Holdoff window of 8 valid samples, with triggers sprinkled in and ignored.
    for (int i = 0; i < 7; i++) drive(1, logic'(i % 2), 0, 5000 + i);
    drive(0, 0, 0, 0);
    check("holdoff_busy_7", busy, 1);
    drive(1, 1, 0, 5007);
    drive(0, 0, 0, 0);
    check("holdoff_exit_busy", busy, 0);
    check("holdoff_exit_armed", armed, AUTO);
    check("sb_drained_a", 32'(sb_q.size()), 0);

    // While armed: a trigger without valid, then valid without a trigger. Neither captures.
    do_reset();
    drive(0, 0, 1, 0);
    drive(0, 1, 0, 123);
    drive(1, 0, 0, 124);
    drive(0, 0, 0, 0);
    check("no_cap_armed", armed, 1);
    check("no_cap_busy", busy, 0);

    // Capture with gaps: the counter stalls and data_out holds between beats.
    outs_before = n_out;
    drive(1, 1, 0, 100); push(100, 1, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, -16); push(-16, 0, 0);
    check("gap_hold_data", data_out, 100);
    check("gap_hold_valid", data_out_valid, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 102); push(102, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 103); push(103, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("gap_out_count", 32'(n_out - outs_before), 4);
    check("gap_holdoff_busy", busy, 1);

    // Reset mid-frame, after two samples, while data_out_valid is still high.
    do_reset();
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 200); push(200, 1, 0);
    drive(1, 0, 0, 201); push(201, 0, 0);
    @(negedge clk);
    data_in_valid = 1'b0; data_in = '0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_data", data_out, 0);
    check("async_rst_valid", data_out_valid, 0);
    check("async_rst_pulses", {30'd0, frame_start, frame_end}, 32'd0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 1, 0, 300);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("post_rst_armed", armed, 0);
    check("post_rst_busy", busy, 0);
    check("sb_drained_end", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 1024, samples per captured frame (1..2^16).
REQ-002 SHALL have parameter HOLDOFF, default 16, valid samples ignored after a frame before re-arm (0..2^16).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  32  signed sample stream.
REQ-006 SHALL have port data_in_valid  input  1  data_in qualifier, one sample per high cycle.
REQ-007 SHALL have port trigger  input  1  trigger flag from the level-crossing trigger; sampled only with data_in_valid.
REQ-008 SHALL have port arm  input  1  single-cycle arm request.
REQ-009 SHALL have port data_out  output  32  signed captured sample.
REQ-010 SHALL have port data_out_valid  output  1  data_out qualifier.
REQ-011 SHALL have port frame_start  output  1  high with first sample of a frame.
REQ-012 SHALL have port frame_end  output  1  high with last sample of a frame.
REQ-013 SHALL have port armed  output  1  high in ARMED state.
REQ-014 SHALL have port busy  output  1  high in CAPTURE or HOLDOFF.

Function
REQ-015 SHALL implement states IDLE, ARMED, CAPTURE, HOLDOFF; armed/busy decoded from registered state.
REQ-016 IDLE -> ARMED SHALL occur on the cycle after arm=1; arm in any other state is ignored.
REQ-017 ARMED -> CAPTURE SHALL occur on a cycle with data_in_valid=1 and trigger=1; that cycle's data_in is sample 0.
REQ-018 trigger=1 with data_in_valid=0 SHALL be ignored.
REQ-019 In CAPTURE each data_in_valid=1 cycle SHALL forward data_in; data_in_valid=0 cycles stall the sample counter.
REQ-020 data_out/data_out_valid/frame_start/frame_end SHALL be registered: exactly 1 cycle latency from the accepted input.
REQ-021 frame_start SHALL mark sample 0, frame_end sample N_SAMPLES-1; for N_SAMPLES=1 both assert on the same beat.
REQ-022 Exactly N_SAMPLES data_out_valid pulses SHALL be emitted per frame; trigger during CAPTURE/HOLDOFF is ignored.
REQ-023 After sample N_SAMPLES-1 the FSM SHALL enter HOLDOFF, counting HOLDOFF valid samples; HOLDOFF=0 leaves it in one cycle.
REQ-024 data_out SHALL hold its last value when data_out_valid=0; outputs other than data_out are single-cycle pulses or state levels.
REQ-025 Sample and holdoff counters SHALL be 17 bits unsigned, cleared on every state entry, never wrapping.
REQ-026 arm and trigger both high in IDLE SHALL only arm; the trigger is not captured.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, counters 0, data_out 0, data_out_valid/frame_start/frame_end/armed/busy 0.
REQ-028 Reset mid-frame SHALL abort the frame with no frame_end; after release, a new arm is required.

Configuration
REQ-029 Macro TRIG_CAPTURE_AUTO_REARM_EN SHALL select HOLDOFF exit: defined -> ARMED (continuous triggered capture); undefined -> IDLE (one-shot, needs arm).

Verification
REQ-030 N_SAMPLES=4, arm, then trigger+valid on sample value 4001 -> data_out 4001..next 3 values, frame_start on 1st, frame_end on 4th, 1-cycle latency.
REQ-031 Trigger with data_in_valid=0, then valid with trigger=0 while ARMED -> no capture, armed stays 1.
REQ-032 Capture with data_in_valid toggling every other cycle, N_SAMPLES=4 -> exactly 4 outputs, counter stalls on gaps.
REQ-033 Second trigger during CAPTURE and during HOLDOFF=8 -> ignored; with macro defined armed=1 after 8 valid samples, undefined -> IDLE.
REQ-034 reset_n low after sample 2 of 4 -> all outputs 0 asynchronously, no frame_end; trigger after release without arm -> no capture.
